// File: rtl/mult32x32_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mult32x32_rr_arbiter
//
// Shares a single 32x32 multiplier (start/busy/product handshake) among N
// client blocks using round-robin arbitration. The winner's operands are
// latched into mult_a/mult_b, mult_start is pulsed for one cycle, and once the
// multiplier drops busy the 64-bit product is captured into result and a
// one-cycle done pulse is returned on the granted requester's lane.
//
// Optional build macro: MULT_ARB_TIMEOUT_EN
//   Defined   : WAIT is bounded to TIMEOUT cycles; on expiry the op is aborted
//               with result=0 and err pulsed together with done.
//   Undefined : WAIT is unbounded and err is tied low.
//
// Parameters
//   N        number of requesters (2..8)
//   TIMEOUT  max WAIT cycles before abort (timeout build only)
//
// Ports
//   clk           clock
//   reset         asynchronous active-high reset
//   req[N]        per-requester request level, held until own done
//   a_in/b_in     packed operands, requester i at bits [32i+31:32i]
//   gnt[N]        one-hot grant, high from grant cycle through done cycle
//   done[N]       one-hot single-cycle completion pulse
//   result[64]    product of last completed op, held until next done
//   err           single-cycle abort pulse (with done) on timeout
//   mult_start    single-cycle start to the multiplier
//   mult_a/mult_b registered operands to the multiplier
//   mult_busy     multiplier busy, rises the cycle after start
//   mult_product  multiplier product, final when busy is low
// ---------------------------------------------------------------------------
module mult32x32_rr_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [N*32-1:0] a_in,
  input  logic [N*32-1:0] b_in,
  output logic [N-1:0]    gnt,
  output logic [N-1:0]    done,
  output logic [63:0]     result,
  output logic            err,
  output logic            mult_start,
  output logic [31:0]     mult_a,
  output logic [31:0]     mult_b,
  input  logic            mult_busy,
  input  logic [63:0]     mult_product
);

  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [N-1:0]   done_q, done_d;
  logic [63:0]    result_q, result_d;
  logic           mult_start_q, mult_start_d;
  logic [31:0]    mult_a_q, mult_a_d;
  logic [31:0]    mult_b_q, mult_b_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [IW-1:0]  win_q, win_d;

  // Unpacked views of the operand buses for indexed selection.
  logic [31:0] a_arr [N];
  logic [31:0] b_arr [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign a_arr[gi] = a_in[32*gi +: 32];
      assign b_arr[gi] = b_in[32*gi +: 32];
    end
  endgenerate

  // Round-robin pick: first set request scanning upward from ptr_q with wrap.
  logic          found;
  logic [IW-1:0] pick;
  logic [IW:0]   scan_sum;

  always_comb begin
    found    = 1'b0;
    pick     = '0;
    scan_sum = '0;
    for (int k = 0; k < N; k++) begin
      scan_sum = {1'b0, ptr_q} + (IW+1)'(k);
      if (scan_sum >= (IW+1)'(N)) begin
        scan_sum = scan_sum - (IW+1)'(N);
      end
      if (!found && req[scan_sum[IW-1:0]]) begin
        found = 1'b1;
        pick  = scan_sum[IW-1:0];
      end
    end
  end

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`else
  // TIMEOUT only matters for the bounded-wait build.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT == 0);
`endif

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    done_d       = '0;
    result_d     = result_q;
    mult_start_d = 1'b0;
    mult_a_d     = mult_a_q;
    mult_b_d     = mult_b_q;
    ptr_d        = ptr_q;
    win_d        = win_q;
`ifdef MULT_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        // A still-busy multiplier blocks new grants.
        if (found && !mult_busy) begin
          state_d      = S_ISSUE;
          win_d        = pick;
          gnt_d        = '0;
          gnt_d[pick]  = 1'b1;
          mult_a_d     = a_arr[pick];
          mult_b_d     = b_arr[pick];
          mult_start_d = 1'b1;  // registered so it is high during ISSUE only
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef MULT_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end

      S_WAIT: begin
        if (!mult_busy) begin
          state_d       = S_DONE;
          result_d      = mult_product;
          done_d[win_q] = 1'b1;
        end
`ifdef MULT_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d       = S_DONE;
          result_d      = '0;
          done_d[win_q] = 1'b1;
          err_d         = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        // Winner drops to lowest priority for the next arbitration.
        ptr_d   = (win_q == IW'(N - 1)) ? '0 : win_q + 1'b1;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      gnt_q        <= '0;
      done_q       <= '0;
      result_q     <= '0;
      mult_start_q <= 1'b0;
      mult_a_q     <= '0;
      mult_b_q     <= '0;
      ptr_q        <= '0;
      win_q        <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      result_q     <= result_d;
      mult_start_q <= mult_start_d;
      mult_a_q     <= mult_a_d;
      mult_b_q     <= mult_b_d;
      ptr_q        <= ptr_d;
      win_q        <= win_d;
    end
  end

`ifdef MULT_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign result     = result_q;
  assign mult_start = mult_start_q;
  assign mult_a     = mult_a_q;
  assign mult_b     = mult_b_q;

endmodule

// File: tb/tb_mult32x32_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mult32x32_rr_arbiter
//
// Directed bench for mult32x32_rr_arbiter with N=4, TIMEOUT=4. A small
// variable-latency multiplier stand-in drives mult_busy/mult_product; the
// product reads as a garbage pattern until busy falls. Inputs are driven and
// outputs checked on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mult32x32_rr_arbiter;

  localparam int N = 4;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*32-1:0] a_in;
  logic [N*32-1:0] b_in;
  logic [N-1:0]    gnt;
  logic [N-1:0]    done;
  logic [63:0]     result;
  logic            err;
  logic            mult_start;
  logic [31:0]     mult_a;
  logic [31:0]     mult_b;
  logic            mult_busy;
  logic [63:0]     mult_product;

  int tests_run;
  int tests_failed;

  mult32x32_rr_arbiter #(
    .N       (N),
    .TIMEOUT (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .a_in         (a_in),
    .b_in         (b_in),
    .gnt          (gnt),
    .done         (done),
    .result       (result),
    .err          (err),
    .mult_start   (mult_start),
    .mult_a       (mult_a),
    .mult_b       (mult_b),
    .mult_busy    (mult_busy),
    .mult_product (mult_product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier stand-in: busy for busy_cycles cycles starting the cycle after
  // start; product becomes final as busy falls.
  int          busy_cycles;
  int          busy_left;
  logic        model_busy;
  logic        hold_busy;
  logic [63:0] pending;
  logic [63:0] prod;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_busy <= 1'b0;
      busy_left  <= 0;
      pending    <= '0;
      prod       <= '0;
    end else if (mult_start) begin
      model_busy <= 1'b1;
      busy_left  <= busy_cycles - 1;
      pending    <= 64'(mult_a) * 64'(mult_b);
      prod       <= 64'hDEAD_BEEF_DEAD_BEEF;
    end else if (model_busy) begin
      if (busy_left == 0) begin
        model_busy <= 1'b0;
        prod       <= pending;
      end else begin
        busy_left <= busy_left - 1;
      end
    end
  end

  assign mult_busy    = model_busy | hold_busy;
  assign mult_product = prod;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    a_in[32*i +: 32] = a;
    b_in[32*i +: 32] = b;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Watchdog: the directed sequence is short, so this only fires on a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    req          = '0;
    a_in         = '0;
    b_in         = '0;
    hold_busy    = 1'b0;
    busy_cycles  = 1;

    // ---------------- reset state ----------------
    step(2);
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_result", result, 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    chk("rst_start", 64'(mult_start), 64'h0);
    chk("rst_mult_a", 64'(mult_a), 64'h0);
    chk("rst_mult_b", 64'(mult_b), 64'h0);
    reset = 1'b0;
    step(1);

    // ---------------- single op: 5*7, busy 1 ----------------
    busy_cycles = 1;
    set_ops(0, 32'd5, 32'd7);
    req = 4'b0001;
    step(1);  // T+1 ISSUE
    chk("single_gnt_t1", 64'(gnt), 64'h1);
    chk("single_start_t1", 64'(mult_start), 64'h1);
    chk("single_mult_a", 64'(mult_a), 64'd5);
    chk("single_mult_b", 64'(mult_b), 64'd7);
    step(1);  // T+2
    chk("single_start_t2", 64'(mult_start), 64'h0);
    chk("single_gnt_t2", 64'(gnt), 64'h1);
    step(1);  // T+3
    chk("single_done_t3", 64'(done), 64'h0);
    step(1);  // T+4
    chk("single_done_t4", 64'(done), 64'h1);
    chk("single_result", result, 64'h23);
    chk("single_gnt_t4", 64'(gnt), 64'h1);
    chk("single_err", 64'(err), 64'h0);
    req = 4'b0000;
    step(1);  // IDLE
    chk("single_gnt_idle", 64'(gnt), 64'h0);
    chk("single_done_idle", 64'(done), 64'h0);
    chk("single_result_held", result, 64'h23);

    // ---------------- full width on requester 2, busy 4 ----------------
    busy_cycles = 4;
    set_ops(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    req = 4'b0100;
    step(1);  // T+1
    chk("full_gnt", 64'(gnt), 64'h4);
    chk("full_start", 64'(mult_start), 64'h1);
    step(5);  // T+6
    chk("full_done_t6", 64'(done), 64'h0);
    chk("full_result_t6", result, 64'h23);
    step(1);  // T+7
    chk("full_done_t7", 64'(done), 64'h4);
    chk("full_result", result, 64'hFFFF_FFFE_0000_0001);
    req = 4'b0000;
    step(1);

    // Reset pulse in IDLE brings the pointer back to requester 0.
    reset = 1'b1;
    step(1);
    chk("pulse_rst_result", result, 64'h0);
    reset = 1'b0;
    step(1);

    // ---------------- round-robin, all four requesting ----------------
    busy_cycles = 1;
    for (int i = 0; i < N; i++) begin
      set_ops(i, 32'(i + 1), 32'd10);
    end
    req = 4'b1111;
    for (int op = 0; op < 5; op++) begin
      int w;
      w = op % N;
      step(1);  // ISSUE
      chk($sformatf("rr%0d_gnt", op), 64'(gnt), 64'(1 << w));
      step(3);  // DONE
      chk($sformatf("rr%0d_done", op), 64'(done), 64'(1 << w));
      chk($sformatf("rr%0d_result", op), result, 64'((w + 1) * 10));
      step(1);  // IDLE gap
      chk($sformatf("rr%0d_gap", op), 64'(gnt), 64'h0);
    end
    req = 4'b0000;
    step(1);
    chk("rr_idle_after", 64'(gnt), 64'h0);

    // ---------------- busy in IDLE / withdrawal ----------------
    hold_busy = 1'b1;
    req = 4'b0010;
    step(2);
    chk("busy_idle_no_gnt", 64'(gnt), 64'h0);
    req = 4'b0000;
    hold_busy = 1'b0;
    step(2);
    chk("withdraw_no_gnt", 64'(gnt), 64'h0);
    chk("withdraw_no_start", 64'(mult_start), 64'h0);

    // ---------------- operand stability ----------------
    busy_cycles = 3;
    set_ops(1, 32'd3, 32'd4);
    req = 4'b0010;
    step(1);  // T+1
    chk("stab_gnt", 64'(gnt), 64'h2);
    step(1);  // T+2 (WAIT)
    set_ops(1, 32'd100, 32'd100);
    step(1);  // T+3
    chk("stab_mult_a", 64'(mult_a), 64'd3);
    chk("stab_mult_b", 64'(mult_b), 64'd4);
    step(3);  // T+6
    chk("stab_done", 64'(done), 64'h2);
    chk("stab_result", result, 64'd12);
    req = 4'b0000;
    step(1);

    // ---------------- reset mid-WAIT ----------------
    busy_cycles = 5;
    set_ops(2, 32'd6, 32'd7);
    req = 4'b0100;
    step(1);  // T+1
    chk("midrst_gnt_before", 64'(gnt), 64'h4);
    step(2);  // T+3, busy high
    reset = 1'b1;
    req   = 4'b0000;
    #1;
    chk("midrst_gnt", 64'(gnt), 64'h0);
    chk("midrst_done", 64'(done), 64'h0);
    chk("midrst_result", result, 64'h0);
    chk("midrst_mult_a", 64'(mult_a), 64'h0);
    step(1);
    reset = 1'b0;
    step(3);
    chk("midrst_no_done", 64'(done), 64'h0);
    chk("midrst_no_gnt", 64'(gnt), 64'h0);

    busy_cycles = 1;
    set_ops(3, 32'd2, 32'd3);
    req = 4'b1000;
    step(1);
    chk("post_rst_gnt3", 64'(gnt), 64'h8);
    step(3);
    chk("post_rst_done3", 64'(done), 64'h8);
    chk("post_rst_result", result, 64'd6);
    req = 4'b0000;
    step(1);

    set_ops(0, 32'd8, 32'd8);
    req = 4'b1001;
    step(1);
    chk("tie_gnt0", 64'(gnt), 64'h1);
    step(3);
    chk("tie_done0", 64'(done), 64'h1);
    chk("tie_result", result, 64'd64);
    req = 4'b0000;
    step(1);

`ifdef MULT_ARB_TIMEOUT_EN
    // ---------------- timeout abort (TIMEOUT=4) ----------------
    busy_cycles = 1;
    set_ops(1, 32'd9, 32'd9);
    req = 4'b0010;
    step(1);  // T+1
    hold_busy = 1'b1;
    step(4);  // T+5, last WAIT cycle
    chk("to_done_t5", 64'(done), 64'h0);
    step(1);  // T+6
    chk("to_done", 64'(done), 64'h2);
    chk("to_err", 64'(err), 64'h1);
    chk("to_result", result, 64'h0);
    hold_busy = 1'b0;
    req = 4'b0000;
    step(1);
    chk("to_err_clear", 64'(err), 64'h0);

    set_ops(2, 32'd4, 32'd5);
    req = 4'b0100;
    step(1);
    chk("to_next_gnt", 64'(gnt), 64'h4);
    step(3);
    chk("to_next_done", 64'(done), 64'h4);
    chk("to_next_result", result, 64'd20);
    chk("to_next_err", 64'(err), 64'h0);
    req = 4'b0000;
    step(1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
